pico_clk_ctrl: RTL and testbench
================================

// Module: pico_clk_ctrl
// PURPOSE
//  Clock-enable scheduler for the PICO16a core. It replaces a free-running divided clock with a
//  single-cycle enable, cpu_ce, in the 50 MHz iclk domain.
//  - Operating modes: halt, full-speed run, slow run (2 Hz visible stepping), manual single-step.
//  - Honours the core's HALT request.
//  - Sits between the board switches/button and the core's clock-enable input.
// PARAMETERS
//  DIV_SLOW   25_000_000  iclk cycles between slow-mode pulses (2 Hz at 50 MHz); must be >= 2
//  DB_CYCLES  1_000_000   stable cycles required to accept a step_btn level change (20 ms)
//  CNT_W      32          width of the slow and debounce counters
// PORTS
//  iclk      in   1  system clock, 50 MHz
//  rst       in   1  asynchronous, active-high reset
//  mode      in   2  switch select: 00 HALT, 01 RUN, 10 SLOW, 11 STEP; asynchronous
//  step_btn  in   1  raw push button, active-high, asynchronous, bouncing
//  cpu_halt  in   1  core executed HALT; synchronous to iclk
//  cpu_ce    out  1  registered clock enable to the core; one-cycle pulses in SLOW/STEP
//  led_tick  out  1  toggles on every cpu_ce pulse in SLOW/STEP; holds its value in other states
//  state     out  2  current state, same encoding as mode
//  halted    out  1  sticky HALT flag
// BEHAVIOUR
//  Reset (async, any time): state=HALT(00), cpu_ce=0, led_tick=0, halted=0.
//    Also clears slow counter, debounce counter/level, and both sync flops.
//    Reset mid-pulse kills the pulse immediately.
//  mode path: 2-FF synchroniser, then state <= mode_sync each cycle.
//    A pin change appears on state at the 3rd iclk edge after the change.
//  On any state change: slow counter <= 0; any pending step pulse is discarded.
//  cpu_ce is registered and computed from the current state:
//    HALT : 0.
//    RUN  : 1 every cycle while !halted. First high at the edge after state becomes RUN.
//    SLOW : slow counter counts 0..DIV_SLOW-1, then wraps to 0.
//           cpu_ce=1 for exactly one cycle at the edge after counter==DIV_SLOW-1.
//           First pulse comes DIV_SLOW cycles after entering SLOW. Counter keeps running while halted.
//    STEP : each debounced rising edge of step_btn gives exactly one cpu_ce pulse, one cycle later.
//           Holding the button yields no further pulses. Release is not an event.
//  Step edges in any state other than STEP are dropped. They are never queued for a later STEP entry.
//  halted:
//    Set at the edge where cpu_halt=1 and cpu_ce=1. cpu_ce is 0 from the following cycle.
//    While halted, cpu_ce=0 in every state.
//    Cleared only when state==HALT; leaving HALT afterwards resumes normally.
//    cpu_halt=1 while cpu_ce=0 is ignored.
//  Simultaneous events:
//    Step edge and state change in the same cycle: the state change wins and no pulse is issued.
//    Slow wrap and cpu_halt in the same cycle: halted is set, and the wrap pulse is suppressed.
//  Debounce:
//    step_btn passes through a 2-FF sync.
//    The counter resets whenever the synced value equals the accepted level.
//    When the counter reaches DB_CYCLES-1 with a differing value, the new level is accepted.
//    A rising acceptance produces a one-cycle edge pulse.
// STRUCTURE
//  pico_clk_defs.vh: `define constants for the mode/state encodings
//    (ST_HALT, ST_RUN, ST_SLOW, ST_STEP) and the default divider values; shared with the core/top.
//  Sub-module btn_debounce (iclk, rst, btn_raw -> btn_level, btn_rise):
//    2-FF sync + DB_CYCLES stability counter + rising-edge pulse.
//    Reused later for the reset and run buttons.
//  Top: mode synchroniser, state register, slow counter, halted flag, cpu_ce/led_tick output registers.
// TESTING (bench uses DIV_SLOW=4, DB_CYCLES=3)
//  1. Reset: rst=1 mid-SLOW while cpu_ce=1.
//     -> cpu_ce=0, state=00, led_tick=0 before the next edge. They stay so until rst=0 plus the mode sync delay.
//  2. RUN: mode 00->01 at edge 0.
//     -> state=01 at edge 3; cpu_ce=1 from edge 4 on, every cycle.
//  3. SLOW: mode=10.
//     -> cpu_ce pulses one cycle every 4 cycles; led_tick toggles 0->1->0 on successive pulses.
//     Switch to RUN mid-count -> counter restarts on the next SLOW entry.
//  4. STEP:
//     a. step_btn high for 1 cycle (glitch) -> no pulse.
//     b. step_btn high for 10 cycles -> exactly one cpu_ce pulse.
//     c. Bouncing 1-0-1 within 2 cycles, then stable -> one pulse.
//  5. HALT flag: in RUN, cpu_halt=1 for 1 cycle.
//     -> halted=1, cpu_ce=0 from the next cycle. Switching to SLOW gives no pulses.
//     mode=00 -> halted=0; then mode=01 -> cpu_ce=1 again.
//  6. Dropped step: press in RUN, then switch to STEP -> no cpu_ce pulse.
//     Next press -> one pulse.

Source files
------------

// File: rtl/pico_clk_ctrl_pkg.sv
// pico_clk_ctrl_pkg: shared state encoding and default timing constants for the clock-enable scheduler
package pico_clk_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_SLOW = 2'b10,
    ST_STEP = 2'b11
  } state_t;
  localparam int DIV_SLOW_DEF  = 25_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF     = 32;
  function automatic logic ticks_led(input state_t s);
    return s == ST_SLOW || s == ST_STEP;
  endfunction
endpackage

// File: rtl/pico_clk_ctrl_if.sv
// pico_clk_ctrl_if: board/core-facing signals of the clock-enable scheduler
interface pico_clk_ctrl_if;
  logic [1:0] mode;
  logic       step_btn;
  logic       cpu_halt;
  logic       cpu_ce;
  logic       led_tick;
  logic [1:0] state;
  logic       halted;
  modport master (output mode, step_btn, cpu_halt, input cpu_ce, led_tick, state, halted);
  modport slave  (input mode, step_btn, cpu_halt, output cpu_ce, led_tick, state, halted);
endinterface

// File: rtl/pico_clk_ctrl_btn_debounce.sv
// btn_debounce: synchronise a bouncing button, accept a level after DB_CYCLES stable cycles, flag rising acceptances
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 32
) (
  input  logic iclk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  // two-flop synchroniser for the raw pin
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end
  // stability counter: a differing value must persist DB_CYCLES samples before it becomes the level
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        cnt       <= '0;
        btn_level <= s2;
        btn_rise  <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/pico_clk_ctrl.sv
// pico_clk_ctrl: schedules single-cycle core clock enables for halt, run, slow and single-step modes
module pico_clk_ctrl
  import pico_clk_ctrl_pkg::*;
#(
  parameter int DIV_SLOW  = DIV_SLOW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic iclk,
  input logic rst,
  pico_clk_ctrl_if.slave bus
);
  logic [1:0] m1, m2;
  state_t st, st_n;
  logic [CNT_W-1:0] slow_cnt, slow_cnt_n;
  logic chg, wrap, hit, fire;
  logic ce_q, ce_n, led_q, led_n, halted_q, halted_n;
  logic step_level, step_rise;
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
    .iclk(iclk),
    .rst(rst),
    .btn_raw(bus.step_btn),
    .btn_level(step_level),
    .btn_rise(step_rise)
  );
  // two-flop synchroniser for the mode switches
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      m1 <= 2'b00;
      m2 <= 2'b00;
    end else begin
      m1 <= bus.mode;
      m2 <= m1;
    end
  end
  // state register follows the synchronised switches
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) st <= ST_HALT;
    else st <= st_n;
  end
  // next state, slow divider, halt tracking and the enable decision for the coming cycle
  always_comb begin
    st_n       = state_t'(m2);
    chg        = st_n != st;
    wrap       = st == ST_SLOW && slow_cnt == CNT_W'(DIV_SLOW - 1);
    hit        = bus.cpu_halt & ce_q;
    slow_cnt_n = (chg || st != ST_SLOW || wrap) ? '0 : slow_cnt + CNT_W'(1);
    fire       = st == ST_RUN || wrap || (st == ST_STEP && step_rise && step_level && !chg);
    ce_n       = fire && !halted_q && !hit;
    halted_n   = st == ST_HALT ? 1'b0 : halted_q | hit;
    led_n      = led_q ^ (ce_n & ticks_led(st));
  end
  // registered outputs and divider state
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      slow_cnt <= '0;
      ce_q     <= 1'b0;
      led_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      slow_cnt <= slow_cnt_n;
      ce_q     <= ce_n;
      led_q    <= led_n;
      halted_q <= halted_n;
    end
  end
  assign bus.cpu_ce   = ce_q;
  assign bus.led_tick = led_q;
  assign bus.state    = st;
  assign bus.halted   = halted_q;
endmodule

// File: tb/tb_pico_clk_ctrl.sv
// tb_pico_clk_ctrl: directed and randomised checks of the clock-enable scheduler against a rule-level model
module tb_pico_clk_ctrl;
  localparam int DIV = 4;
  localparam int DB  = 3;
  logic iclk = 1'b0;
  logic rst  = 1'b1;
  int pass_cnt = 0;
  int total    = 0;
  pico_clk_ctrl_if b();
  pico_clk_ctrl #(.DIV_SLOW(DIV), .DB_CYCLES(DB), .CNT_W(32)) dut (.iclk(iclk), .rst(rst), .bus(b));
  always #5 iclk = ~iclk;
  // reference model: state is the switch value sampled two edges earlier, slow pulses every DIV edges
  // after entry, a button level is accepted once its synchronised value has held DB samples
  int n, slow_start;
  logic [1:0] mq[$];
  bit bq[$];
  logic [1:0] es, ns;
  bit ece, eled, eh, lvl, rise_prev, chg, fire, hit, sv, stable, ce_new;
  initial forever begin
    @(posedge iclk or posedge rst);
    if (rst) begin
      n = 0; slow_start = 0; es = 2'b00; ece = 0; eled = 0; eh = 0; lvl = 0; rise_prev = 0;
      mq.delete(); bq.delete();
      repeat (6) bq.push_back(1'b0);
    end else begin
      n++;
      mq.push_back(b.mode);
      if (mq.size() > 3) void'(mq.pop_front());
      ns = (mq.size() == 3) ? mq[0] : 2'b00;
      chg = ns != es;
      fire = (es == 2'b01) || (es == 2'b10 && n > slow_start && (n - slow_start) % DIV == 0) ||
             (es == 2'b11 && rise_prev && !chg);
      hit = b.cpu_halt && ece;
      ce_new = fire && !eh && !hit;
      eh = (es == 2'b00) ? 1'b0 : (eh || hit);
      if (ce_new && es[1]) eled = ~eled;
      ece = ce_new;
      if (chg) slow_start = n;
      es = ns;
      bq.push_back(b.step_btn);
      if (bq.size() > 8) void'(bq.pop_front());
      sv = bq[bq.size()-3];
      stable = 1;
      for (int i = 0; i < DB; i++) if (bq[bq.size()-3-i] != sv) stable = 0;
      rise_prev = 0;
      if (sv != lvl && stable) begin lvl = sv; rise_prev = sv; end
    end
  end
  function automatic logic [4:0] obs();
    return {b.cpu_ce, b.led_tick, b.state, b.halted};
  endfunction
  function automatic logic [4:0] expv();
    return {ece, eled, es, eh};
  endfunction

  task automatic test_reset;
    rst = 1; b.mode = 2'b00; b.step_btn = 0; b.cpu_halt = 0;
    repeat (3) begin
      @(negedge iclk); total++;
      if (obs() !== 5'b0) $display("FAIL reset_hold got %b exp 00000", obs()); else pass_cnt++;
    end
    rst = 0;
    repeat (4) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL reset_idle n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
  endtask

  task automatic test_run;
    b.mode = 2'b01;
    repeat (2) @(posedge iclk);
    #1 total++;
    if (b.state !== 2'b00) $display("FAIL run_edge2_state got %b exp 00", b.state); else pass_cnt++;
    @(posedge iclk);
    #1 total++;
    if ({b.state, b.cpu_ce} !== 3'b010) $display("FAIL run_edge3 got %b exp 010", {b.state, b.cpu_ce}); else pass_cnt++;
    @(posedge iclk);
    #1 total++;
    if (b.cpu_ce !== 1'b1) $display("FAIL run_edge4_ce got %b exp 1", b.cpu_ce); else pass_cnt++;
    repeat (8) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL run_model n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
  endtask

  task automatic test_slow;
    int pulses, toggles;
    logic pl;
    b.mode = 2'b10;
    repeat (3) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL slow_enter n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    total++;
    if (b.state !== 2'b10) $display("FAIL slow_state got %b exp 10", b.state); else pass_cnt++;
    pulses = 0; toggles = 0; pl = b.led_tick;
    repeat (24) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL slow_model n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      pulses += int'(b.cpu_ce); toggles += int'(b.led_tick != pl); pl = b.led_tick;
    end
    total++;
    if (pulses != 6) $display("FAIL slow_pulses got %0d exp 6", pulses); else pass_cnt++;
    total++;
    if (toggles != 6) $display("FAIL slow_led_toggles got %0d exp 6", toggles); else pass_cnt++;
    repeat ($urandom_range(1, 2)) @(negedge iclk);
    b.mode = 2'b01;
    repeat (6) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL slow_torun n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    b.mode = 2'b10;
    repeat (3) @(negedge iclk);
    pulses = 0;
    repeat (3) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL slow_reentry n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      pulses += int'(b.cpu_ce);
    end
    total++;
    if (pulses != 0) $display("FAIL slow_restart_early got %0d exp 0", pulses); else pass_cnt++;
    @(negedge iclk); total++;
    if (b.cpu_ce !== 1'b1) $display("FAIL slow_restart_pulse got %b exp 1", b.cpu_ce); else pass_cnt++;
    rst = 1;
    #1 total++;
    if (obs() !== 5'b0) $display("FAIL reset_midpulse got %b exp 00000", obs()); else pass_cnt++;
    repeat (2) begin
      @(negedge iclk); total++;
      if (obs() !== 5'b0) $display("FAIL reset_midslow_hold got %b exp 00000", obs()); else pass_cnt++;
    end
    rst = 0;
    repeat (2) @(posedge iclk);
    #1 total++;
    if (b.state !== 2'b00) $display("FAIL reset_release_state got %b exp 00", b.state); else pass_cnt++;
    @(posedge iclk);
    #1 total++;
    if (b.state !== 2'b10) $display("FAIL reset_resync_state got %b exp 10", b.state); else pass_cnt++;
    repeat (10) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL slow_after_reset n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
  endtask

  task automatic test_step;
    logic [23:0] pat [4];
    int expc [4];
    int d, pulses;
    d = $urandom_range(1, 10);
    pat[0] = 24'h000001; expc[0] = 0;
    pat[1] = 24'h0003FF; expc[1] = 1;
    pat[2] = 24'h000FFD; expc[2] = 1;
    pat[3] = (24'd1 << d) - 24'd1; expc[3] = (d >= DB) ? 1 : 0;
    b.mode = 2'b11;
    repeat (6) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL step_enter n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    for (int p = 0; p < 4; p++) begin
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
        @(negedge iclk); total++;
        if (obs() !== expv()) $display("FAIL step_model p=%0d n=%0d got %b exp %b", p, n, obs(), expv()); else pass_cnt++;
        pulses += int'(b.cpu_ce);
        b.step_btn = pat[p][i];
      end
      total++;
      if (pulses != expc[p]) $display("FAIL step_pulses p=%0d got %0d exp %0d", p, pulses, expc[p]); else pass_cnt++;
    end
  endtask

  task automatic test_halt;
    int pulses;
    b.mode = 2'b01;
    repeat (5) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL halt_run n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    b.cpu_halt = 1;
    @(negedge iclk);
    b.cpu_halt = 0;
    total++;
    if ({b.halted, b.cpu_ce} !== 2'b10) $display("FAIL halt_set got %b exp 10", {b.halted, b.cpu_ce}); else pass_cnt++;
    b.mode = 2'b10;
    pulses = 0;
    repeat (20) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL halt_slow n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      pulses += int'(b.cpu_ce);
    end
    total++;
    if (pulses != 0) $display("FAIL halt_slow_pulses got %0d exp 0", pulses); else pass_cnt++;
    b.mode = 2'b00;
    repeat (4) @(negedge iclk);
    total++;
    if (b.halted !== 1'b0) $display("FAIL halt_clear got %b exp 0", b.halted); else pass_cnt++;
    b.mode = 2'b01;
    repeat (5) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL halt_resume n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    total++;
    if (b.cpu_ce !== 1'b1) $display("FAIL halt_resume_ce got %b exp 1", b.cpu_ce); else pass_cnt++;
  endtask

  task automatic test_dropped_step;
    int pulses;
    b.step_btn = 1;
    repeat (10) @(negedge iclk);
    b.step_btn = 0;
    repeat (8) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL drop_run n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
    end
    b.mode = 2'b11;
    repeat (4) @(negedge iclk);
    pulses = 0;
    repeat (12) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL drop_step n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      pulses += int'(b.cpu_ce);
    end
    total++;
    if (pulses != 0) $display("FAIL drop_pulses got %0d exp 0", pulses); else pass_cnt++;
    pulses = 0;
    b.step_btn = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL drop_next n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      pulses += int'(b.cpu_ce);
      if (i == 9) b.step_btn = 0;
    end
    total++;
    if (pulses != 1) $display("FAIL drop_next_pulses got %0d exp 1", pulses); else pass_cnt++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      @(negedge iclk); total++;
      if (obs() !== expv()) $display("FAIL random n=%0d got %b exp %b", n, obs(), expv()); else pass_cnt++;
      if ($urandom_range(0, 24) == 0) b.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b.step_btn = ~b.step_btn;
      b.cpu_halt = ($urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_slow();
    test_step();
    test_halt();
    test_dropped_step();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
